// File: rtl/tl_ul_host_pkg.sv
// Shared TileLink-UL constants, host FSM state encoding and the natural byte-mask helper.
package tl_ul_host_pkg;

    localparam logic [2:0] TL_A_MSG_PUT_FULL    = 3'd0;
    localparam logic [2:0] TL_A_MSG_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] TL_A_MSG_GET         = 3'd4;
    localparam logic [2:0] TL_D_MSG_ACK         = 3'd0;
    localparam logic [2:0] TL_D_MSG_ACK_DATA    = 3'd1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_A_SEND = 2'd1;
    localparam logic [1:0] ST_D_WAIT = 2'd2;
    localparam logic [1:0] ST_RSP    = 2'd3;

    // Byte lanes covered by an access of 2^size bytes at the given low address bits.
    function automatic logic [3:0] natural_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'd0:    natural_mask = 4'b0001 << addr_lo;
            2'd1:    natural_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default: natural_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/tl_ul_host_mask.sv
// Combinational request legality check: natural mask, alignment and write-mask subset test.
module tl_ul_host_mask
    import tl_ul_host_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    input  logic       we,
    input  logic [3:0] req_mask,
    output logic [3:0] nat_mask,
    output logic       legal,
    output logic       full
);

    logic aligned;

    always_comb begin
        nat_mask = natural_mask(size, addr_lo);
        case (size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = ~addr_lo[0];
            2'd2:    aligned = (addr_lo == 2'b00);
            default: aligned = 1'b0;
        endcase
        legal = aligned && (!we || ((req_mask & ~nat_mask) == 4'b0000));
        full  = (req_mask == nat_mask);
    end

endmodule

// File: rtl/tl_ul_host.sv
// Single-outstanding TileLink-UL host: CPU request -> one-beat A message -> D result -> CPU response.
// Optional D-wait watchdog enabled by defining TL_HOST_TIMEOUT_EN.
module tl_ul_host
    import tl_ul_host_pkg::*;
#(
    parameter int   ADDR_WIDTH     = 25,
    parameter logic SOURCE_ID      = 1'b0,
    parameter int   TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  host_i_req_valid,
    output logic                  host_o_req_ready,
    input  logic                  host_i_req_we,
    input  logic [ADDR_WIDTH-1:0] host_i_req_addr,
    input  logic [1:0]            host_i_req_size,
    input  logic [3:0]            host_i_req_mask,
    input  logic [31:0]           host_i_req_wdata,
    output logic                  host_o_rsp_valid,
    input  logic                  host_i_rsp_ready,
    output logic [31:0]           host_o_rsp_rdata,
    output logic                  host_o_rsp_err,
    output logic [2:0]            host_o_tl_a_opcode,
    output logic [2:0]            host_o_tl_a_param,
    output logic [3:0]            host_o_tl_a_size,
    output logic                  host_o_tl_a_source,
    output logic [ADDR_WIDTH-1:0] host_o_tl_a_address,
    output logic [3:0]            host_o_tl_a_mask,
    output logic [31:0]           host_o_tl_a_data,
    output logic                  host_o_tl_a_corrupt,
    output logic                  host_o_tl_a_valid,
    input  logic                  host_i_tl_a_ready,
    input  logic [2:0]            host_i_tl_d_opcode,
    input  logic [1:0]            host_i_tl_d_param,
    input  logic [3:0]            host_i_tl_d_size,
    input  logic                  host_i_tl_d_source,
    input  logic                  host_i_tl_d_sink,
    input  logic                  host_i_tl_d_denied,
    input  logic [31:0]           host_i_tl_d_data,
    input  logic                  host_i_tl_d_corrupt,
    input  logic                  host_i_tl_d_valid,
    output logic                  host_o_tl_d_ready,
    output logic [1:0]            dbg_state
);

    // Every port pair moves data exactly on a clock edge where valid and ready are both high;
    // a valid side keeps its payload unchanged until that edge, and ready never depends on valid.

    logic [1:0] state;
    logic       is_read;
    logic [3:0] nat_mask;
    logic       req_legal;
    logic       req_full;
    logic [2:0] d_exp_opcode;
    logic       d_err;
    logic       unused_d;

    assign dbg_state = state;
    assign unused_d  = ^{host_i_tl_d_param, host_i_tl_d_sink};

    tl_ul_host_mask u_mask (
        .size     (host_i_req_size),
        .addr_lo  (host_i_req_addr[1:0]),
        .we       (host_i_req_we),
        .req_mask (host_i_req_mask),
        .nat_mask (nat_mask),
        .legal    (req_legal),
        .full     (req_full)
    );

    always_comb begin
        d_exp_opcode = is_read ? TL_D_MSG_ACK_DATA : TL_D_MSG_ACK;
        d_err = host_i_tl_d_denied
              | (host_i_tl_d_opcode != d_exp_opcode)
              | (host_i_tl_d_source != SOURCE_ID)
              | (host_i_tl_d_size != host_o_tl_a_size)
              | (is_read & host_i_tl_d_corrupt);
    end

`ifdef TL_HOST_TIMEOUT_EN
    logic [31:0] to_cnt;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= ST_IDLE;
            is_read             <= 1'b0;
            host_o_req_ready    <= 1'b0;
            host_o_rsp_valid    <= 1'b0;
            host_o_rsp_rdata    <= 32'h0;
            host_o_rsp_err      <= 1'b0;
            host_o_tl_a_opcode  <= 3'h0;
            host_o_tl_a_param   <= 3'h0;
            host_o_tl_a_size    <= 4'h0;
            host_o_tl_a_source  <= 1'b0;
            host_o_tl_a_address <= '0;
            host_o_tl_a_mask    <= 4'h0;
            host_o_tl_a_data    <= 32'h0;
            host_o_tl_a_corrupt <= 1'b0;
            host_o_tl_a_valid   <= 1'b0;
            host_o_tl_d_ready   <= 1'b0;
`ifdef TL_HOST_TIMEOUT_EN
            to_cnt              <= 32'h0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    host_o_req_ready <= 1'b1;
                    if (host_i_req_valid && host_o_req_ready) begin
                        host_o_req_ready <= 1'b0;
                        is_read          <= ~host_i_req_we;
                        if (req_legal) begin
                            state               <= ST_A_SEND;
                            host_o_tl_a_valid   <= 1'b1;
                            host_o_tl_a_opcode  <= !host_i_req_we ? TL_A_MSG_GET :
                                                   (req_full ? TL_A_MSG_PUT_FULL : TL_A_MSG_PUT_PARTIAL);
                            host_o_tl_a_param   <= 3'h0;
                            host_o_tl_a_size    <= {2'b00, host_i_req_size};
                            host_o_tl_a_source  <= SOURCE_ID;
                            host_o_tl_a_address <= host_i_req_addr;
                            host_o_tl_a_mask    <= host_i_req_we ? host_i_req_mask : nat_mask;
                            host_o_tl_a_data    <= host_i_req_we ? host_i_req_wdata : 32'h0;
                            host_o_tl_a_corrupt <= 1'b0;
                        end else begin
                            // Illegal requests short-circuit to an error response with no bus traffic.
                            state            <= ST_RSP;
                            host_o_rsp_valid <= 1'b1;
                            host_o_rsp_err   <= 1'b1;
                            host_o_rsp_rdata <= 32'h0;
                        end
                    end
                end
                ST_A_SEND: begin
                    if (host_o_tl_a_valid && host_i_tl_a_ready) begin
                        state             <= ST_D_WAIT;
                        host_o_tl_a_valid <= 1'b0;
                        host_o_tl_d_ready <= 1'b1;
`ifdef TL_HOST_TIMEOUT_EN
                        to_cnt            <= 32'h0;
`endif
                    end
                end
                ST_D_WAIT: begin
                    if (host_i_tl_d_valid && host_o_tl_d_ready) begin
                        state             <= ST_RSP;
                        host_o_tl_d_ready <= 1'b0;
                        host_o_rsp_valid  <= 1'b1;
                        host_o_rsp_err    <= d_err;
                        host_o_rsp_rdata  <= (is_read && !d_err) ? host_i_tl_d_data : 32'h0;
                    end
`ifdef TL_HOST_TIMEOUT_EN
                    else if (to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                        state             <= ST_RSP;
                        host_o_tl_d_ready <= 1'b0;
                        host_o_rsp_valid  <= 1'b1;
                        host_o_rsp_err    <= 1'b1;
                        host_o_rsp_rdata  <= 32'h0;
                    end else begin
                        to_cnt <= to_cnt + 32'h1;
                    end
`endif
                end
                ST_RSP: begin
                    if (host_i_rsp_ready) begin
                        state            <= ST_IDLE;
                        host_o_rsp_valid <= 1'b0;
                        host_o_rsp_err   <= 1'b0;
                        host_o_rsp_rdata <= 32'h0;
                        host_o_req_ready <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_ul_host.sv
// Bench for tl_ul_host: directed cases plus randomized traffic against a TL slave model and scoreboard.
module tb_tl_ul_host;

    localparam int   AW  = 25;
    localparam int   TO  = 16;
    localparam logic SRC = 1'b0;

    localparam int K_OK = 0, K_DENIED = 1, K_WRONG_OP = 2, K_WRONG_SRC = 3, K_WRONG_SIZE = 4, K_CORRUPT = 5;

    logic          clk, rst;
    logic          req_valid, req_ready, req_we;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_size;
    logic [3:0]    req_mask;
    logic [31:0]   req_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [31:0]   rsp_rdata;
    logic [2:0]    a_opcode, a_param;
    logic [3:0]    a_size, a_mask;
    logic          a_source, a_corrupt, a_valid, a_ready;
    logic [AW-1:0] a_address;
    logic [31:0]   a_data;
    logic [2:0]    d_opcode;
    logic [1:0]    d_param;
    logic [3:0]    d_size;
    logic          d_source, d_sink, d_denied, d_corrupt, d_valid, d_ready;
    logic [31:0]   d_data;
    logic [1:0]    dbg_state;

    tl_ul_host #(.ADDR_WIDTH(AW), .SOURCE_ID(SRC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .host_i_req_valid(req_valid), .host_o_req_ready(req_ready), .host_i_req_we(req_we),
        .host_i_req_addr(req_addr), .host_i_req_size(req_size), .host_i_req_mask(req_mask),
        .host_i_req_wdata(req_wdata),
        .host_o_rsp_valid(rsp_valid), .host_i_rsp_ready(rsp_ready),
        .host_o_rsp_rdata(rsp_rdata), .host_o_rsp_err(rsp_err),
        .host_o_tl_a_opcode(a_opcode), .host_o_tl_a_param(a_param), .host_o_tl_a_size(a_size),
        .host_o_tl_a_source(a_source), .host_o_tl_a_address(a_address), .host_o_tl_a_mask(a_mask),
        .host_o_tl_a_data(a_data), .host_o_tl_a_corrupt(a_corrupt), .host_o_tl_a_valid(a_valid),
        .host_i_tl_a_ready(a_ready),
        .host_i_tl_d_opcode(d_opcode), .host_i_tl_d_param(d_param), .host_i_tl_d_size(d_size),
        .host_i_tl_d_source(d_source), .host_i_tl_d_sink(d_sink), .host_i_tl_d_denied(d_denied),
        .host_i_tl_d_data(d_data), .host_i_tl_d_corrupt(d_corrupt), .host_i_tl_d_valid(d_valid),
        .host_o_tl_d_ready(d_ready),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          total = 0;
    int          bad   = 0;
    int          d_hs  = 0;
    logic [32:0] exp_q[$];
    logic [72:0] exp_a_q[$];
    logic [72:0] a_now;

    int          cfg_kind, cfg_a_stall, cfg_d_delay;
    bit          cfg_no_d, cfg_early;
    logic [31:0] cfg_rdata;

    assign a_now = {a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt};

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- TL slave model ----------------
    initial begin : slave
        logic [2:0] aop;
        logic [3:0] asz;
        int         w;
        a_ready = 1'b0; d_valid = 1'b0; d_opcode = '0; d_param = '0; d_size = '0;
        d_source = 1'b0; d_sink = 1'b0; d_denied = 1'b0; d_data = '0; d_corrupt = 1'b0;
        forever begin
            @(negedge clk);
            if (a_valid === 1'b1 && rst === 1'b0) begin
                aop = a_opcode;
                asz = a_size;
                repeat (cfg_a_stall) @(negedge clk);
                a_ready = 1'b1;
                if (cfg_early) begin
                    d_valid = 1'b1; d_denied = 1'b1; d_data = ~cfg_rdata;
                end
                @(negedge clk);
                a_ready = 1'b0;
                d_valid = 1'b0;
                if (!cfg_no_d) begin
                    repeat (cfg_d_delay) @(negedge clk);
                    d_valid   = 1'b1;
                    d_opcode  = ((aop == 3'd4) ? 3'd1 : 3'd0) ^ ((cfg_kind == K_WRONG_OP) ? 3'd1 : 3'd0);
                    d_param   = 2'd0;
                    d_size    = asz ^ ((cfg_kind == K_WRONG_SIZE) ? 4'd1 : 4'd0);
                    d_source  = SRC ^ (cfg_kind == K_WRONG_SRC);
                    d_sink    = 1'($urandom);
                    d_denied  = (cfg_kind == K_DENIED);
                    d_corrupt = (cfg_kind == K_CORRUPT);
                    d_data    = cfg_rdata;
                    w = 0;
                    while (d_ready !== 1'b1 && w < 8) begin
                        @(negedge clk);
                        w++;
                    end
                    @(negedge clk);
                    d_valid = 1'b0; d_denied = 1'b0; d_corrupt = 1'b0; d_data = $urandom;
                end
            end
        end
    end

    // ---------------- monitor: pops and compares on every handshake ----------------
    initial begin : monitor
        logic [72:0] prev_a;
        logic [32:0] prev_r;
        bit          prev_a_pend, prev_r_pend;
        prev_a_pend = 0; prev_r_pend = 0; prev_a = '0; prev_r = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b1) begin
                prev_a_pend = 0;
                prev_r_pend = 0;
            end else begin
                if (prev_a_pend) chk("a_hold", {a_valid, a_now}, {1'b1, prev_a});
                if (a_valid === 1'b1) begin
                    if (exp_a_q.size() == 0) chk("a_unexpected", a_valid, 1'b0);
                    else if (a_ready === 1'b1) chk("a_beat", a_now, exp_a_q.pop_front());
                end
                prev_a_pend = (a_valid === 1'b1) && (a_ready !== 1'b1);
                prev_a = a_now;
                if (d_valid === 1'b1 && d_ready === 1'b1) d_hs++;
                if (prev_r_pend) chk("rsp_hold", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, prev_r});
                if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                    if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 1'b0);
                    else chk("rsp", {rsp_err, rsp_rdata}, exp_q.pop_front());
                end
                prev_r_pend = (rsp_valid === 1'b1) && (rsp_ready !== 1'b1);
                prev_r = {rsp_err, rsp_rdata};
            end
        end
    end

    // ---------------- driver tasks (entered at a negedge) ----------------
    task automatic send_req(input logic we, input logic [AW-1:0] addr, input logic [1:0] size,
                            input logic [3:0] mask, input logic [31:0] wdata);
        int k;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_mask = mask; req_wdata = wdata; rsp_ready = 1'b0;
        #2;
        k = 0;
        while (req_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("req_wait", k, 0);
        @(negedge clk);
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = AW'($urandom); req_size = 2'($urandom);
        req_mask = 4'($urandom); req_wdata = $urandom;
    endtask

    task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [1:0] size,
                           input logic [3:0] mask, input logic [31:0] wdata, input logic [31:0] rdata,
                           input int kind, input int a_stall, input int d_delay, input int rsp_stall,
                           input bit no_d);
        int          sz, left, n, dr, hs0, exp_dr;
        bit          legal, timed_out, err, done;
        logic [3:0]  nat;
        logic [2:0]  op;
        sz = size;
        legal = (sz <= 2) && ((addr % (1 << sz)) == 0);
        nat = (sz <= 2) ? 4'(((1 << (1 << sz)) - 1) << addr[1:0]) : 4'h0;
        if (we && legal && ((mask & ~nat) != 4'h0)) legal = 0;
        timed_out = no_d || (d_delay >= TO);
        cfg_kind = kind; cfg_a_stall = a_stall; cfg_d_delay = d_delay; cfg_no_d = no_d; cfg_rdata = rdata;
        if (legal) begin
            op = !we ? 3'd4 : ((mask == nat) ? 3'd0 : 3'd1);
            exp_a_q.push_back({op, 3'd0, {2'b00, size}, SRC, addr, we ? mask : nat, we ? wdata : 32'h0, 1'b0});
        end
        if (!legal || timed_out) err = 1;
        else err = (kind == K_DENIED) || (kind == K_WRONG_OP) || (kind == K_WRONG_SRC) ||
                   (kind == K_WRONG_SIZE) || (kind == K_CORRUPT && !we);
        exp_q.push_back({err, (!err && !we) ? rdata : 32'h0});
        exp_dr = !legal ? 0 : (timed_out ? TO : d_delay + 1);
        hs0 = d_hs;
        send_req(we, addr, size, mask, wdata);
        done = 0; n = 0; dr = 0; left = rsp_stall;
        while (!done && n < 400) begin
            rsp_ready = (rsp_valid === 1'b1) && (left == 0);
            if (rsp_valid === 1'b1 && left > 0) left--;
            #2;
            if (d_ready === 1'b1) dr++;
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) done = 1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk("txn_done", done, 1'b1);
        chk("d_ready_cycles", dr, exp_dr);
        chk("d_beats", d_hs - hs0, (legal && !timed_out) ? 1 : 0);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic reset_in_dwait();
        int k;
        cfg_a_stall = 0; cfg_no_d = 1;
        exp_a_q.push_back({3'd4, 3'd0, 4'd2, SRC, 25'h40, 4'hF, 32'h0, 1'b0});
        send_req(1'b0, 25'h40, 2'd2, 4'h0, 32'h0);
        #2;
        k = 0;
        while (d_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("reach_dwait", d_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("mid_rst_outs", {a_valid, d_ready, rsp_valid, rsp_err, rsp_rdata, a_now}, 80'h0);
        chk("mid_rst_state", dbg_state, 2'd0);
        @(negedge clk);
        #2;
        chk("mid_rst_ready", req_ready, 1'b1);
        @(negedge clk);
        cfg_no_d = 0;
    endtask

    // ---------------- stimulus and final report ----------------
    initial begin : main
        logic       we;
        logic [1:0] sz;
        logic [3:0] msk, nat;
        logic [AW-1:0] ad;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
        req_mask = '0; req_wdata = '0; rsp_ready = 1'b0;
        cfg_kind = K_OK; cfg_a_stall = 0; cfg_d_delay = 0; cfg_no_d = 0; cfg_early = 0; cfg_rdata = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_outs", {a_valid, d_ready, rsp_valid, rsp_err, rsp_rdata, a_now}, 80'h0);
        chk("rst_state", dbg_state, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk("rst_req_ready", req_ready, 1'b1);
        @(negedge clk);

        run_txn(1'b0, 25'h10, 2'd2, 4'h0, 32'h0, 32'hDEADBEEF, K_OK, 0, 0, 0, 0);
        run_txn(1'b1, 25'h10, 2'd0, 4'h1, 32'h40, 32'h1234, K_OK, 0, 0, 0, 0);
        run_txn(1'b1, 25'h10, 2'd2, 4'h3, 32'h5566, 32'h0, K_OK, 0, 1, 0, 0);
        run_txn(1'b1, 25'h12, 2'd1, 4'h4, 32'h77000000, 32'h0, K_OK, 1, 0, 0, 0);
        run_txn(1'b0, 25'h20, 2'd2, 4'h0, 32'h0, 32'hCAFEF00D, K_OK, 5, 0, 3, 0);
        run_txn(1'b0, 25'h24, 2'd2, 4'h0, 32'h0, 32'h11111111, K_DENIED, 0, 0, 0, 0);
        run_txn(1'b1, 25'h24, 2'd2, 4'hF, 32'h9, 32'h0, K_WRONG_OP, 0, 2, 0, 0);
        run_txn(1'b0, 25'h28, 2'd1, 4'h0, 32'h0, 32'h22222222, K_WRONG_SRC, 0, 0, 0, 0);
        run_txn(1'b0, 25'h2A, 2'd1, 4'h0, 32'h0, 32'h33333333, K_WRONG_SIZE, 0, 0, 0, 0);
        run_txn(1'b0, 25'h2B, 2'd0, 4'h0, 32'h0, 32'h44444444, K_CORRUPT, 0, 0, 0, 0);
        run_txn(1'b1, 25'h2C, 2'd2, 4'hF, 32'h5, 32'h55555555, K_CORRUPT, 0, 0, 0, 0);
        run_txn(1'b0, 25'h11, 2'd2, 4'h0, 32'h0, 32'h66666666, K_OK, 0, 0, 2, 0);
        run_txn(1'b0, 25'h10, 2'd3, 4'h0, 32'h0, 32'h0, K_OK, 0, 0, 0, 0);
        run_txn(1'b1, 25'h12, 2'd1, 4'h3, 32'h0, 32'h0, K_OK, 0, 0, 0, 0);
        cfg_early = 1;
        run_txn(1'b0, 25'h30, 2'd2, 4'h0, 32'h0, 32'h0BADF00D, K_OK, 0, 1, 0, 0);
        cfg_early = 0;

        reset_in_dwait();
        run_txn(1'b0, 25'h44, 2'd2, 4'h0, 32'h0, 32'hA5A5A5A5, K_OK, 0, 0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            we  = 1'($urandom);
            sz  = 2'($urandom_range(0, 3));
            ad  = AW'($urandom);
            nat = (sz <= 2) ? 4'(((1 << (1 << sz)) - 1) << ad[1:0]) : 4'h0;
            msk = ($urandom_range(0, 1) == 1) ? nat : 4'($urandom);
            run_txn(we, ad, sz, msk, $urandom, $urandom, $urandom_range(0, 5),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 0);
        end

`ifdef TL_HOST_TIMEOUT_EN
        begin
            int hs_before;
            run_txn(1'b0, 25'h50, 2'd2, 4'h0, 32'h0, 32'h12345678, K_OK, 0, 20, 0, 0);
            hs_before = d_hs;
            repeat (20) @(negedge clk);
            chk("late_d_dropped", d_hs - hs_before, 0);
            run_txn(1'b0, 25'h54, 2'd2, 4'h0, 32'h0, 32'h87654321, K_OK, 0, 0, 0, 0);
        end
`endif

        repeat (4) @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 0);
        chk("exp_a_q_empty", exp_a_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
